// File: rtl/shift_add_multiplier_if.sv
// Start/ready handshake and operand/result buses shared by the shift-add multiplier
// and its datapath controller.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic             st;
    logic [WIDTH-1:0] Qbus_in;
    logic [WIDTH-1:0] Mbus_in;
    logic [WIDTH-1:0] Abus_out;
    logic [WIDTH-1:0] Qbus_out;
    logic             ready;

    modport master (
        output st,
        output Qbus_in,
        output Mbus_in,
        input  Abus_out,
        input  Qbus_out,
        input  ready
    );

    modport slave (
        input  st,
        input  Qbus_in,
        input  Mbus_in,
        output Abus_out,
        output Qbus_out,
        output ready
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one iteration per clock, product on {Abus_out,Qbus_out}.
// Define SIGNED_MUL_EN to build a radix-2 Booth two's-complement multiplier instead.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    shift_add_multiplier_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   acc;

`ifdef SIGNED_MUL_EN
    logic q_m1;

    // acc is one bit wider than A so that subtracting the most negative M keeps its sign
    always_comb begin
        acc = {a_reg[WIDTH-1], a_reg};
        case ({q_reg[0], q_m1})
            2'b10:   acc = {a_reg[WIDTH-1], a_reg} - {m_reg[WIDTH-1], m_reg};
            2'b01:   acc = {a_reg[WIDTH-1], a_reg} + {m_reg[WIDTH-1], m_reg};
            default: acc = {a_reg[WIDTH-1], a_reg};
        endcase
    end
`else
    logic c_reg;

    always_comb begin
        acc = {c_reg, a_reg};
        if (q_reg[0]) begin
            acc = {c_reg, a_reg} + {1'b0, m_reg};
        end
    end
`endif

    // Shifting {acc,Q} right by one drops acc's top bit into A's MSB in both modes
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            q_reg <= '0;
            m_reg <= '0;
            cnt   <= '0;
`ifdef SIGNED_MUL_EN
            q_m1  <= 1'b0;
`else
            c_reg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.st) begin
                        a_reg <= '0;
                        q_reg <= bus.Qbus_in;
                        m_reg <= bus.Mbus_in;
                        cnt   <= CNT_W'(WIDTH);
                        state <= BUSY;
`ifdef SIGNED_MUL_EN
                        q_m1  <= 1'b0;
`else
                        c_reg <= 1'b0;
`endif
                    end
                end
                BUSY: begin
                    a_reg <= acc[WIDTH:1];
                    q_reg <= {acc[0], q_reg[WIDTH-1:1]};
                    cnt   <= cnt - CNT_W'(1);
`ifdef SIGNED_MUL_EN
                    q_m1  <= q_reg[0];
`else
                    c_reg <= 1'b0;
`endif
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.Abus_out = a_reg;
    assign bus.Qbus_out = q_reg;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: expected products are queued at start and
// popped when ready returns. Signed cases are added when SIGNED_MUL_EN is defined.
module tb_shift_add_multiplier;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [15:0] expectedQ[$];

    shift_add_multiplier_if #(.WIDTH(8)) bus ();

    shift_add_multiplier #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] modelProduct(input logic [7:0] q, input logic [7:0] m);
`ifdef SIGNED_MUL_EN
        int sq;
        int sm;
        sq = (q >= 8'h80) ? int'(q) - 256 : int'(q);
        sm = (m >= 8'h80) ? int'(m) - 256 : int'(m);
        return 16'(sq * sm);
`else
        return 16'(int'(q) * int'(m));
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    // Drive one start; keepSt leaves st high after the sampling edge
    task automatic applyStimulus(input logic [7:0] q, input logic [7:0] m, input bit keepSt, input bit record);
        @(negedge clk);
        bus.st      = 1'b1;
        bus.Qbus_in = q;
        bus.Mbus_in = m;
        if (record) expectedQ.push_back(modelProduct(q, m));
        @(posedge clk);
        #1;
        if (!keepSt) bus.st = 1'b0;
    endtask

    task automatic waitResult(input string tag);
        int busy;
        logic [15:0] expected;
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready) break;
            busy++;
        end
        checkOutput({tag, "_busy"}, 16'(busy), 16'd8);
        if (expectedQ.size() == 0) begin
            checkOutput({tag, "_sbempty"}, 16'd1, 16'd0);
        end else begin
            expected = expectedQ.pop_front();
            checkOutput({tag, "_prod"}, {bus.Abus_out, bus.Qbus_out}, expected);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.st      = 1'b0;
        bus.Qbus_in = '0;
        bus.Mbus_in = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", 16'(bus.ready), 16'd1);
        checkOutput("rst_abus", 16'(bus.Abus_out), 16'h0000);
        checkOutput("rst_qbus", 16'(bus.Qbus_out), 16'h0000);

        applyStimulus(8'hDB, 8'h0C, 1'b0, 1'b1);
        waitResult("db_0c");
        applyStimulus(8'hBC, 8'h1C, 1'b0, 1'b1);
        waitResult("bc_1c");
        applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1);
        waitResult("ff_ff");
        applyStimulus(8'h00, 8'hD7, 1'b0, 1'b1);
        waitResult("00_d7");
        applyStimulus(8'hD7, 8'h13, 1'b0, 1'b1);
        waitResult("d7_13");

        // st held: operands changed mid-op must not disturb the running product
        applyStimulus(8'hDB, 8'h0C, 1'b1, 1'b1);
        bus.Qbus_in = 8'h11;
        bus.Mbus_in = 8'h22;
        waitResult("held_first");
        expectedQ.push_back(modelProduct(8'h11, 8'h22));
        @(posedge clk);
        #1 bus.st = 1'b0;
        waitResult("held_second");

        // Reset during busy cycle 4 aborts the operation
        applyStimulus(8'hDB, 8'h0C, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready", 16'(bus.ready), 16'd1);
        checkOutput("abort_prod", {bus.Abus_out, bus.Qbus_out}, 16'h0000);
        applyStimulus(8'hDB, 8'h0C, 1'b0, 1'b1);
        waitResult("after_abort");

        // Reset and start on the same edge: reset wins
        @(negedge clk);
        rst         = 1'b1;
        bus.st      = 1'b1;
        bus.Qbus_in = 8'h55;
        bus.Mbus_in = 8'h33;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        bus.st = 1'b0;
        @(negedge clk);
        checkOutput("rst_st_ready", 16'(bus.ready), 16'd1);
        checkOutput("rst_st_prod", {bus.Abus_out, bus.Qbus_out}, 16'h0000);

`ifdef SIGNED_MUL_EN
        applyStimulus(8'hFF, 8'h02, 1'b0, 1'b1);
        waitResult("s_ff_02");
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b1);
        waitResult("s_80_80");
        applyStimulus(8'h7F, 8'h81, 1'b0, 1'b1);
        waitResult("s_7f_81");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
